frame_scan_ctrl: RTL

Read-side scan sequencer for the bilateral filter accelerator. It sits directly upstream of the frame block memory read port and walks every centre pixel of a stored frame in raster order, issuing one `row_r`/`col_r` address per accepted cycle on `addr_r_valid`. It bounds the number of in-flight window reads and tags each returned 7x7 window (`pixel_r_valid`) with its centre coordinate and a last-of-frame flag for the downstream filter kernel.

---
 rtl/frame_scan_pkg.sv | 20 ++
 rtl/coord_tag_fifo.sv | 39 +++
 rtl/frame_scan_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/frame_scan_pkg.sv
// Shared types and defaults for the frame read-side scan sequencer.
package frame_scan_pkg;

  localparam int MAX_OUT_DEF = 4;
  localparam int AW_DEF      = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic [AW_DEF-1:0] row;
    logic [AW_DEF-1:0] col;
    logic              last;
  } coord_t;

endpackage

// File: rtl/coord_tag_fifo.sv
// In-order tag FIFO holding the centre coordinate of every in-flight window read.
module coord_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_q;
  logic [PW:0]  rd_q;
  logic         empty;

  assign empty = (wr_q == rd_q);
  // Show-ahead head reads as zero when nothing is outstanding.
  assign head  = empty ? '0 : mem[rd_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/frame_scan_ctrl.sv
// Raster-order read address sequencer with bounded in-flight window reads
// and centre-coordinate tagging of returned windows.
module frame_scan_ctrl
  import frame_scan_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] cfg_rows,
  input  logic [AW-1:0] cfg_cols,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] row_r,
  output logic [AW-1:0] col_r,
  output logic          addr_r_valid,
  input  logic          pixel_r_valid,
  output logic [AW-1:0] win_row,
  output logic [AW-1:0] win_col,
  output logic          win_last,
  output logic          err
);

  localparam int             CW       = $clog2(MAX_OUT) + 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_OUT);
  localparam logic [1:0]     S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0]     S_SCAN   = 2'(ST_SCAN);
  localparam logic [1:0]     S_DRAIN  = 2'(ST_DRAIN);
  localparam logic [1:0]     S_DONE   = 2'(ST_DONE);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rows_q, cols_q;
  logic [AW-1:0] nrow_q, ncol_q;
  logic [CW-1:0] cnt_q, cnt_after;
  logic          empty_frame_q;

  logic          accept, cfg_zero, scanning, ret, issue, iss_last;
  logic [AW-1:0] lim_rows, lim_cols;
  logic [2*AW:0] tag_head;

  assign cfg_zero  = (cfg_rows == '0) || (cfg_cols == '0);
  assign accept    = (state_q == S_IDLE) && start;
  // The accepting edge already issues (0,0), so limits come straight from cfg then.
  assign lim_rows  = accept ? cfg_rows : rows_q;
  assign lim_cols  = accept ? cfg_cols : cols_q;
  assign scanning  = (state_q == S_SCAN) || (accept && !cfg_zero);
  assign ret       = pixel_r_valid && (cnt_q != '0);
  assign cnt_after = cnt_q - CW'(ret);
  assign issue     = scanning && !stall && (cnt_after < CNT_MAX);
  assign iss_last  = (nrow_q == lim_rows - AW'(1)) && (ncol_q == lim_cols - AW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = cfg_zero ? S_DONE :
                                    (issue && iss_last) ? S_DRAIN : S_SCAN;
      S_SCAN:  if (issue && iss_last) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rows_q        <= '0;
      cols_q        <= '0;
      nrow_q        <= '0;
      ncol_q        <= '0;
      cnt_q         <= '0;
      empty_frame_q <= 1'b0;
      row_r         <= '0;
      col_r         <= '0;
      addr_r_valid  <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_r_valid <= issue;
      cnt_q        <= cnt_after + CW'(issue);
      if (pixel_r_valid && (cnt_q == '0)) err <= 1'b1;
      if (accept) begin
        rows_q        <= cfg_rows;
        cols_q        <= cfg_cols;
        empty_frame_q <= cfg_zero;
      end
      if (issue) begin
        row_r <= nrow_q;
        col_r <= ncol_q;
        if (ncol_q == lim_cols - AW'(1)) begin
          ncol_q <= '0;
          nrow_q <= nrow_q + AW'(1);
        end else begin
          ncol_q <= ncol_q + AW'(1);
        end
      end
      if (state_q == S_DONE) begin
        nrow_q <= '0;
        ncol_q <= '0;
      end
    end
  end

  // An empty frame never reaches SCAN, so busy covers its single DONE cycle instead.
  assign busy = (state_q == S_SCAN) || (state_q == S_DRAIN) ||
                ((state_q == S_DONE) && empty_frame_q);
  assign done = (state_q == S_DONE);

  coord_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (2*AW+1)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data ({nrow_q, ncol_q, iss_last}),
    .pop       (ret),
    .head      (tag_head)
  );

  assign {win_row, win_col, win_last} = tag_head;

endmodule
